xy_router_cb: RTL and testbench
===============================

# xy_router_cb

Parametrised 5-port mesh router tile with per-input flit FIFOs, dimension-ordered (XY) routing, per-output round-robin switch allocation and credit-based flow control. It is the successor of the fixed 16-bit request/answer router: data width, coordinate width, input buffer depth and downstream credit count are parameters. Back-pressure is by credits rather than per-flit handshakes. One instance sits at each mesh node; port 4 connects to the local network interface.

## Interface
- LL, 16, flit width in bits
- MM, 2, coordinate width; destination X = flit[LL-1 -: MM], destination Y = flit[LL-MM-1 -: MM]
- DEPTH, 4, input FIFO depth per port, power of two, >= 2
- CRED, 4, initial credits per output; equals downstream DEPTH
- Port index everywhere: 0 = R (+X), 1 = L (-X), 2 = U (+Y), 3 = D (-Y), 4 = EJ (local)

- clk, input, 1, rising-edge clock
- reset, input, 1, reset, synchronous, active-high
- X, Y, input, MM each, this node's coordinates, static
- in_data, input, 5*LL, flit per input port; port p at [p*LL +: LL]
- in_valid, input, 5, flit present on port p this cycle
- in_credit, output, 5, registered one-cycle pulse to upstream: one slot freed in input FIFO p
- out_data, output, 5*LL, registered flit per output port
- out_valid, output, 5, registered; flit on out_data slice valid this cycle
- out_credit, input, 5, one-cycle pulse from downstream: one credit returned for output p
- ovf_err, output, 5, sticky; in_valid seen on a full FIFO

## Operation
- Input stage: on each edge where in_valid[p]=1, write in_data slice into FIFO p. If FIFO p is full, drop the flit, set ovf_err[p], and leave FIFO contents unchanged.
- Route compute is combinational on each non-empty FIFO head:
  - dx>X -> 0
  - dx<X -> 1
  - else dy>Y -> 2
  - else dy<Y -> 3
  - else -> 4
  - Comparisons are unsigned MM-bit.
- Switch allocation, per output o, each cycle:
  - Requesters are inputs whose head routes to o.
  - Allocation is allowed only if credit[o] > 0.
  - Grant goes round-robin starting at index ptr[o] and searching upward mod 5.
  - On a grant to input i, ptr[o] becomes (i+1) mod 5. Without a grant, ptr[o] is unchanged.
- Each input has a single head flit, so it requests at most one output and receives at most one grant per cycle.
- On a grant from input i to output o at an edge:
  - out_data[o] <= head of FIFO i and out_valid[o] <= 1.
  - FIFO i pops.
  - in_credit[i] <= 1 for that one cycle.
  - credit[o] decrements.
- Outputs without a grant drive out_valid[o] <= 0. out_data holds its last value.
- Credit counter: width clog2(CRED+1).
  - out_credit pulse alone: +1.
  - Grant alone: -1.
  - Both in the same cycle: unchanged.
  - An out_credit pulse when credit == CRED saturates at CRED.
- Simultaneous write and pop on a FIFO in the same cycle: both take effect.
  - A write to a full FIFO that also pops that cycle is accepted; no ovf_err.
  - A flit written into an empty FIFO is not visible to allocation until the next cycle (no bypass).
- U-turn (route equal to arrival port) is permitted and not checked.

## Timing
- Reset (synchronous): all FIFOs empty, ptr[*]=0, credit[*]=CRED, out_valid=0, out_data=0, in_credit=0, ovf_err=0. Reset asserted mid-packet discards all buffered flits; no credits are returned for them.
- Latency: flit sampled at edge t -> at FIFO head after t -> granted at edge t+1 -> out_valid high in the cycle after t+1. Minimum 2 edges, in_valid to out_valid.
- in_credit[i] asserts in the same cycle as the corresponding out_valid.
- Throughput: 1 flit/cycle per output and per input. With one active source, 4 active outputs and CRED >= 3, flow is sustained without bubbles.
- Credit-out-of-zero: an out_credit pulse at edge t makes credit > 0; allocation to that output can occur at edge t+1 at the earliest.

## Test plan
- Route directed: X=1, Y=1; inject one flit on port 4 for each of dest (2,1), (0,1), (1,2), (1,0), (1,1) -> out_valid on ports 0, 1, 2, 3, 4 respectively, each 2 edges after injection, with in_credit[4] pulsing once per flit.
- Round-robin: X=Y=0, after reset; inputs 1, 2, 3 each hold 3 flits to dest (0,0) -> EJ output grant order 1,2,3,1,2,3,1,2,3 on consecutive cycles; ptr[4]=4 at the end.
- Credit stall: CRED=4, out_credit held 0, 6 flits to port 0 -> exactly 4 out_valid pulses, then stall. One out_credit pulse -> 5th flit appears 2 cycles later. A simultaneous grant and credit return leaves credit unchanged.
- Full FIFO: DEPTH=4, output 0 credits exhausted, 5 back-to-back flits on input 1 -> first 4 buffered, 5th dropped, ovf_err[1]=1 and sticky; no ovf_err for a write coinciding with a pop.
- Mid-operation reset: 3 flits buffered on input 2 and credit[3]=1; assert reset for one cycle -> all FIFOs empty, credit[*]=4, no out_valid, no in_credit pulses, ovf_err cleared.
- All-to-all concurrency: 5 inputs each to a distinct output in the same cycle -> 5 out_valid in the same cycle, 5 in_credit pulses, no stalls.

Source files
------------

// File: rtl/xy_router_cb_if.sv
// Bus bundle for one xy_router_cb tile: five flit inputs with credit return to the
// upstream side, and five registered flit outputs with credit return from downstream.
//   in_data/in_valid   : flit per input port p at in_data[p*LL +: LL]
//   in_credit          : one-cycle pulse per freed input FIFO slot
//   out_data/out_valid : registered flit per output port
//   out_credit         : one-cycle credit return pulse per output
//   ovf_err            : sticky per-input overflow flags
// The master modport is the environment side (sources and sinks), the slave modport is the router.
interface xy_router_cb_if #(
  parameter int unsigned LL = 16
) ();
  logic [5*LL-1:0] in_data;
  logic [4:0]      in_valid;
  logic [4:0]      in_credit;
  logic [5*LL-1:0] out_data;
  logic [4:0]      out_valid;
  logic [4:0]      out_credit;
  logic [4:0]      ovf_err;

  modport master (
    output in_data, in_valid, out_credit,
    input  in_credit, out_data, out_valid, ovf_err
  );

  modport slave (
    input  in_data, in_valid, out_credit,
    output in_credit, out_data, out_valid, ovf_err
  );
endinterface

// File: rtl/xy_router_cb.sv
// Five-port mesh router tile: per-input flit FIFOs, XY dimension-ordered routing,
// per-output round-robin switch allocation and credit-based flow control.
// Port index: 0 = +X, 1 = -X, 2 = +Y, 3 = -Y, 4 = local ejection.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   X, Y   : this node's coordinates (static)
//   bus    : flit/credit bundle (slave side), see xy_router_cb_if
module xy_router_cb #(
  parameter int unsigned LL    = 16,
  parameter int unsigned MM    = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CRED  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MM-1:0] X,
  input  logic [MM-1:0] Y,
  xy_router_cb_if.slave bus
);

  localparam int unsigned NP  = 5;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CRW = $clog2(CRED + 1);

  typedef logic [LL-1:0] flit_t;

  flit_t          mem_q      [NP][DEPTH];
  logic [AW-1:0]  wr_ptr_q   [NP];
  logic [AW-1:0]  wr_ptr_d   [NP];
  logic [AW-1:0]  rd_ptr_q   [NP];
  logic [AW-1:0]  rd_ptr_d   [NP];
  logic [CW-1:0]  cnt_q      [NP];
  logic [CW-1:0]  cnt_d      [NP];
  logic [2:0]     ptr_q      [NP];
  logic [2:0]     ptr_d      [NP];
  logic [CRW-1:0] credit_q   [NP];
  logic [CRW-1:0] credit_d   [NP];
  flit_t          out_data_q [NP];
  flit_t          out_data_d [NP];
  logic [NP-1:0]  out_valid_q, out_valid_d;
  logic [NP-1:0]  in_credit_q, in_credit_d;
  logic [NP-1:0]  ovf_err_q, ovf_err_d;

  flit_t          head       [NP];
  logic [2:0]     route      [NP];
  logic [NP-1:0]  nonempty;
  logic [NP-1:0]  req        [NP];
  logic [NP-1:0]  gnt_vld;
  logic [2:0]     gnt_src    [NP];
  logic [NP-1:0]  pop;
  logic [NP-1:0]  push;

  // Round-robin search: first requester at or above ptr, wrapping mod 5.
  // Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [NP-1:0] r, input logic [2:0] p);
    int unsigned c;
    logic        found;
    logic [2:0]  idx;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < NP; k++) begin
      c = int'(p) + k;
      if (c >= NP) c = c - NP;
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = 3'(c);
      end
    end
    return {found, idx};
  endfunction

  // Route compute on every FIFO head.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      head[p]     = mem_q[p][rd_ptr_q[p]];
      nonempty[p] = (cnt_q[p] != '0);
      if (head[p][LL-1 -: MM] > X)            route[p] = 3'd0;
      else if (head[p][LL-1 -: MM] < X)       route[p] = 3'd1;
      else if (head[p][LL-MM-1 -: MM] > Y)    route[p] = 3'd2;
      else if (head[p][LL-MM-1 -: MM] < Y)    route[p] = 3'd3;
      else                                    route[p] = 3'd4;
    end
  end

  // Switch allocation, one arbiter per output, gated by available credit.
  always_comb begin
    logic [3:0] pick;
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        req[o][i] = nonempty[i] && (route[i] == 3'(o));
      end
      pick       = rr_pick(req[o], ptr_q[o]);
      gnt_vld[o] = pick[3] && (credit_q[o] != '0);
      gnt_src[o] = pick[2:0];
      ptr_d[o]   = ptr_q[o];
      if (gnt_vld[o]) begin
        ptr_d[o]         = (gnt_src[o] == 3'd4) ? 3'd0 : gnt_src[o] + 3'd1;
        pop[gnt_src[o]]  = 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a write into a full FIFO.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      push[p]      = bus.in_valid[p] && ((cnt_q[p] != CW'(DEPTH)) || pop[p]);
      wr_ptr_d[p]  = wr_ptr_q[p] + AW'(push[p]);
      rd_ptr_d[p]  = rd_ptr_q[p] + AW'(pop[p]);
      cnt_d[p]     = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      ovf_err_d[p] = ovf_err_q[p] | (bus.in_valid[p] & ~push[p]);
    end
  end

  // Output registers and credit counters.
  always_comb begin
    in_credit_d = pop;
    out_valid_d = gnt_vld;
    for (int o = 0; o < NP; o++) begin
      out_data_d[o] = gnt_vld[o] ? head[gnt_src[o]] : out_data_q[o];
      credit_d[o]   = credit_q[o];
      unique case ({bus.out_credit[o], gnt_vld[o]})
        2'b10: if (credit_q[o] != CRW'(CRED)) credit_d[o] = credit_q[o] + CRW'(1);
        2'b01: credit_d[o] = credit_q[o] - CRW'(1);
        default: credit_d[o] = credit_q[o];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        cnt_q[p]      <= '0;
        ptr_q[p]      <= '0;
        credit_q[p]   <= CRW'(CRED);
        out_data_q[p] <= '0;
      end
      out_valid_q <= '0;
      in_credit_q <= '0;
      ovf_err_q   <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p]   <= wr_ptr_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
        cnt_q[p]      <= cnt_d[p];
        ptr_q[p]      <= ptr_d[p];
        credit_q[p]   <= credit_d[p];
        out_data_q[p] <= out_data_d[p];
      end
      out_valid_q <= out_valid_d;
      in_credit_q <= in_credit_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Flit storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (!reset && push[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_data[p*LL +: LL];
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int o = 0; o < NP; o++) bus.out_data[o*LL +: LL] = out_data_q[o];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_credit = in_credit_q;
  assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_xy_router_cb.sv
// Self-checking bench for xy_router_cb: a queue-based reference model tracks every
// buffered flit, credit and round-robin pointer; a compare process checks all outputs
// each cycle, and directed scenarios add literal expectations.
module tb_xy_router_cb;
  localparam int unsigned LL    = 16;
  localparam int unsigned MM    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CRED  = 4;
  localparam int unsigned TB    = LL - 2 * MM;

  logic          clk;
  logic          reset;
  logic [MM-1:0] X, Y;

  xy_router_cb_if #(.LL(LL)) bus ();

  xy_router_cb #(.LL(LL), .MM(MM), .DEPTH(DEPTH), .CRED(CRED)) dut (
    .clk  (clk),
    .reset(reset),
    .X    (X),
    .Y    (Y),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [LL-1:0] q [5][$];
  int            cred [5];
  int            ptr  [5];
  logic [LL-1:0] exp_od [5];
  logic [4:0]    exp_ov, exp_ic, exp_ovf;
  bit            mdl_live = 0;

  function automatic int route_of(input logic [LL-1:0] f);
    int dx, dy;
    dx = int'(f >> (LL - MM)) % (1 << MM);
    dy = int'(f >> TB) % (1 << MM);
    if (dx > int'(X)) return 0;
    if (dx < int'(X)) return 1;
    if (dy > int'(Y)) return 2;
    if (dy < int'(Y)) return 3;
    return 4;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int p = 0; p < 5; p++) begin
          q[p].delete();
          cred[p]   = CRED;
          ptr[p]    = 0;
          exp_od[p] = '0;
        end
        exp_ov   = '0;
        exp_ic   = '0;
        exp_ovf  = '0;
        mdl_live = 1;
      end else if (mdl_live) begin
        bit g [5];
        int src [5];
        logic [4:0] nov, nic;
        nov = '0;
        nic = '0;
        // Decide every grant from the pre-edge state before anything is popped.
        for (int o = 0; o < 5; o++) begin
          g[o] = 0;
          src[o] = 0;
          if (cred[o] > 0) begin
            for (int k = 0; k < 5; k++) begin
              int i;
              i = (ptr[o] + k) % 5;
              if (!g[o] && q[i].size() > 0 && route_of(q[i][0]) == o) begin
                g[o] = 1;
                src[o] = i;
              end
            end
          end
        end
        for (int o = 0; o < 5; o++) begin
          if (g[o]) begin
            exp_od[o]   = q[src[o]].pop_front();
            nov[o]      = 1'b1;
            nic[src[o]] = 1'b1;
            ptr[o]      = (src[o] + 1) % 5;
            cred[o]     = cred[o] - 1;
          end
          if (bus.out_credit[o]) cred[o] = (cred[o] + 1 > CRED) ? CRED : cred[o] + 1;
        end
        for (int p = 0; p < 5; p++) begin
          if (bus.in_valid[p]) begin
            if (q[p].size() < DEPTH) q[p].push_back(bus.in_data[p*LL +: LL]);
            else exp_ovf[p] = 1'b1;
          end
        end
        exp_ov = nov;
        exp_ic = nic;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_live && !reset) begin
        logic [5*LL-1:0] e;
        for (int o = 0; o < 5; o++) e[o*LL +: LL] = exp_od[o];
        checks += 4;
        if (bus.out_valid !== exp_ov) begin
          errors++;
          $display("FAIL model out_valid t=%0t: got %b expected %b", $time, bus.out_valid, exp_ov);
        end
        if (bus.in_credit !== exp_ic) begin
          errors++;
          $display("FAIL model in_credit t=%0t: got %b expected %b", $time, bus.in_credit, exp_ic);
        end
        if (bus.ovf_err !== exp_ovf) begin
          errors++;
          $display("FAIL model ovf_err t=%0t: got %b expected %b", $time, bus.ovf_err, exp_ovf);
        end
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL model out_data t=%0t: got %h expected %h", $time, bus.out_data, e);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [LL-1:0] mk(input int dx, input int dy, input int tag);
    return LL'((dx << (LL - MM)) + (dy << TB) + (tag % (1 << TB)));
  endfunction

  task automatic put(input int p, input int dx, input int dy, input int tag);
    bus.in_data[p*LL +: LL] = mk(dx, dy, tag);
    bus.in_valid[p] = 1'b1;
  endtask

  function automatic int tag_of(input int o);
    return int'(bus.out_data[o*LL +: LL]) % (1 << TB);
  endfunction

  task automatic do_reset(input int nx, input int ny);
    bus.in_valid   = '0;
    bus.out_credit = '0;
    X = MM'(nx);
    Y = MM'(ny);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int dxs [5] = '{2, 0, 1, 1, 1};
  int dys [5] = '{1, 1, 2, 0, 1};
  int order [$];
  int cyc [$];
  int cnt;

  initial begin
    reset = 1'b1;
    X = '0;
    Y = '0;
    bus.in_data    = '0;
    bus.in_valid   = '0;
    bus.out_credit = '0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_credit", bus.in_credit, 0);
    chk("reset ovf_err", bus.ovf_err, 0);
    chk("reset out_data nonzero", (bus.out_data != '0), 0);

    // Route directed from the local port at node (1,1).
    do_reset(1, 1);
    for (int k = 0; k < 5; k++) begin
      put(4, dxs[k], dys[k], 16'h100 + k);
      tick();
      bus.in_valid = '0;
      chk("route one-edge latency", bus.out_valid, 0);
      tick();
      chk($sformatf("route dest%0d out_valid", k), bus.out_valid, 64'(1) << k);
      chk($sformatf("route dest%0d in_credit", k), bus.in_credit, 5'b10000);
      chk($sformatf("route dest%0d tag", k), tag_of(k), 16'h100 + k);
      tick();
    end

    // Round-robin onto the ejection port.
    do_reset(0, 0);
    bus.out_credit = 5'b10000;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = '0;
      if (c < 3) for (int i = 1; i <= 3; i++) put(i, 0, 0, i * 16 + c);
      tick();
      if (bus.out_valid[4]) begin
        order.push_back(tag_of(4) / 16);
        cyc.push_back(c);
      end
    end
    chk("rr grant count", order.size(), 9);
    if (order.size() == 9) begin
      for (int k = 0; k < 9; k++) chk($sformatf("rr order[%0d]", k), order[k], (k % 3) + 1);
      chk("rr consecutive", cyc[8] - cyc[0], 8);
    end
    // Pointer now at 4: input 4 must beat input 0.
    put(0, 0, 0, 16'h0a);
    put(4, 0, 0, 16'h4a);
    tick();
    bus.in_valid = '0;
    tick();
    chk("rr ptr wrap first", tag_of(4), 16'h4a);
    tick();
    chk("rr ptr wrap second", tag_of(4), 16'h0a);
    bus.out_credit = '0;

    // Credit stall on output 0.
    do_reset(0, 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = '0;
      if (c < 6) put(4, 1, 0, c);
      tick();
      if (bus.out_valid[0]) cnt++;
    end
    bus.in_valid = '0;
    chk("stall pulse count", cnt, 4);
    bus.out_credit = 5'b00001;
    tick();
    bus.out_credit = '0;
    chk("credit-return one edge", bus.out_valid[0], 0);
    tick();
    chk("credit-return 5th flit", bus.out_valid[0], 1);
    chk("credit-return 5th tag", tag_of(0), 4);
    bus.out_credit = 5'b00001;
    tick();
    chk("credit 0->1 no grant", bus.out_valid[0], 0);
    tick();
    bus.out_credit = '0;
    chk("grant+credit 6th flit", bus.out_valid[0], 1);
    put(4, 1, 0, 7);
    tick();
    bus.in_valid = '0;
    tick();
    chk("credit kept after grant+return", bus.out_valid[0], 1);

    // Full FIFO behaviour.
    do_reset(0, 0);
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = '0;
      if (c < 4) put(4, 1, 0, c);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = '0;
      put(3, 1, 0, 16'h30 + c);
      tick();
    end
    bus.in_valid = '0;
    bus.out_credit = 5'b00001;
    tick();
    bus.out_credit = '0;
    put(3, 1, 0, 16'h3f);
    tick();
    bus.in_valid = '0;
    chk("write with pop no ovf", bus.ovf_err, 0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = '0;
      put(1, 1, 0, 16'h10 + c);
      tick();
      if (c == 3) chk("ovf after 4 writes", bus.ovf_err, 0);
    end
    bus.in_valid = '0;
    chk("ovf on 5th write", bus.ovf_err, 5'b00010);
    tick();
    tick();
    chk("ovf sticky", bus.ovf_err, 5'b00010);

    // Mid-operation reset discards buffered flits.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset in_credit", bus.in_credit, 0);
    chk("midreset ovf_err", bus.ovf_err, 0);
    bus.out_credit = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midreset flushed", {bus.out_valid, bus.in_credit}, 0);
    end
    bus.out_credit = '0;

    // All-to-all in one cycle.
    do_reset(1, 1);
    for (int p = 0; p < 5; p++) put(p, dxs[(p + 1) % 5], dys[(p + 1) % 5], 16'h50 + p);
    tick();
    bus.in_valid = '0;
    tick();
    chk("all-to-all out_valid", bus.out_valid, 5'b11111);
    chk("all-to-all in_credit", bus.in_credit, 5'b11111);
    chk("all-to-all tag out0", tag_of(0), 16'h54);

    // Randomized traffic against the model.
    do_reset($urandom_range(0, 3), $urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 5; p++) begin
        bus.in_valid[p]   = ($urandom_range(0, 99) < 40);
        bus.in_data[p*LL +: LL] = LL'($urandom);
        bus.out_credit[p] = ($urandom_range(0, 99) < 35);
      end
      if (c % 700 == 699) do_reset($urandom_range(0, 3), $urandom_range(0, 3));
      else tick();
    end
    bus.in_valid = '0;
    bus.out_credit = 5'b11111;
    for (int c = 0; c < 40; c++) tick();
    chk("drained out_valid", bus.out_valid, 0);
    bus.out_credit = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
